// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg: register map, edge-mode codes and helpers shared by the GPIO slave.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: two-flop synchroniser followed by per-bit stability counters producing deb_in.
module pio_debounce
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] deb_in
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta    <= '0;
            sync_in <= '0;
        end else begin
            meta    <= in_port;
            sync_in <= meta;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk) begin
            if (reset)
                deb_in <= '0;
            else
                deb_in <= sync_in;
        end
    end else begin : g_count
        localparam int CW = clog2(DEBOUNCE_CYCLES) + 1;
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
        logic [CW-1:0] cnt [WIDTH];
        // A bit is accepted only after it has differed from deb_in for DEBOUNCE_CYCLES cycles in a row.
        always_ff @(posedge clk) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (reset) begin
                    cnt[i]    <= '0;
                    deb_in[i] <= 1'b0;
                end else if (sync_in[i] == deb_in[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    deb_in[i] <= sync_in[i];
                    cnt[i]    <= '0;
                end else if (cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/avalon_pio_edge.sv
// avalon_pio_edge: Avalon-MM bidirectional GPIO with atomic set/clear, debounced edge capture and masked irq.
module avalon_pio_edge
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter logic [WIDTH-1:0] DIR_RESET       = '0,
    parameter int               EDGE_TYPE       = EDGE_RISE,
    parameter int               DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    logic             wr;
    logic             wd_unused;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] deb_in;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd;

    pio_debounce #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .in_port(in_port),
        .deb_in (deb_in)
    );

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign wd_unused = ^writedata;
    assign rise      = deb_in & ~deb_prev;
    assign fall      = ~deb_in & deb_prev;
    assign edge_det  = (EDGE_TYPE == EDGE_RISE) ? rise :
                       (EDGE_TYPE == EDGE_FALL) ? fall : (rise | fall);
    assign clr       = (wr && address == ADDR_EDGE) ? wd : '0;

    always_comb begin
        rd = (address == ADDR_DATA) ? ((direction & data_out) | (~direction & deb_in)) :
             (address == ADDR_DIR)  ? direction :
             (address == ADDR_MASK) ? irq_mask :
             (address == ADDR_EDGE) ? edge_cap : '0;
        readdata = 32'(rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= RESET_VALUE;
            direction <= DIR_RESET;
            irq_mask  <= '0;
            edge_cap  <= '0;
            deb_prev  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr && address == ADDR_DATA)
                data_out <= wd;
            else if (wr && address == ADDR_OUTSET)
                data_out <= data_out | wd;
            else if (wr && address == ADDR_OUTCLR)
                data_out <= data_out & ~wd;
            if (wr && address == ADDR_DIR)
                direction <= wd;
            if (wr && address == ADDR_MASK)
                irq_mask <= wd;
            // A new edge outranks a simultaneous write-1-to-clear so no event is lost.
            edge_cap <= (edge_cap & ~clr) | edge_det;
            deb_prev <= deb_in;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    assign out_port = data_out;
    assign out_en   = direction;

endmodule
